// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared defaults, state type and sizing helper for the UART TX arbiter
package uart_tx_arbiter_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // MAX_BURST==0 means unlimited; keep a 1-bit counter that is simply never advanced.
    function automatic int cnt_width(input int max_burst);
        return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational rotating-priority picker: first request at or after ptr
module uart_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N = DEF_NUM_REQ,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          any_o
);

    logic [PW:0] idx;

    always_comb begin
        gnt_o = '0;
        any_o = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr_i} + (PW+1)'(i);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!any_o && req_i[idx[PW-1:0]]) begin
                gnt_o[idx[PW-1:0]] = 1'b1;
                any_o              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx byte stream among requesters
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          tx_valid_o,
    input  logic                          tx_ready_i,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = cnt_width(MAX_BURST);

    arb_state_e            state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [CW-1:0]         burst_q, burst_d;

    logic [NUM_REQ-1:0]    pick_gnt;
    logic                  pick_any;
    logic [PW-1:0]         owner_idx;
    logic [PW-1:0]         next_ptr;
    logic                  owner_valid;
    logic                  owner_last;
    logic [DATA_WIDTH-1:0] owner_data;
    logic                  burst_hit;

    uart_rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .any_o (pick_any)
    );

    always_comb begin
        owner_idx   = '0;
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_q[k]) begin
                owner_idx   = PW'(k);
                owner_valid = req_valid_i[k];
                owner_last  = req_last_i[k];
                owner_data  = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign next_ptr  = (owner_idx == PW'(NUM_REQ - 1)) ? '0 : owner_idx + PW'(1);
    assign burst_hit = (MAX_BURST > 0) && (burst_q == CW'(MAX_BURST - 1));

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        burst_d     = burst_q;
        tx_valid_o  = 1'b0;
        tx_data_o   = '0;
        req_ready_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_gnt;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                tx_valid_o  = owner_valid;
                tx_data_o   = owner_data;
                req_ready_o = grant_q & {NUM_REQ{tx_ready_i}};
                if (owner_valid && tx_ready_i) begin
                    if (MAX_BURST > 0) begin
                        burst_d = burst_q + CW'(1);
                    end
                    // Last byte and burst limit on the same transfer collapse into one release.
                    if (owner_last || burst_hit) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        ptr_d   = next_ptr;
                        burst_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                burst_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == ST_LOCKED);

endmodule
